sha256_mem_arbiter: RTL and testbench
=====================================

Name: sha256_mem_arbiter

Overview:
- Shares the single-port message/hash SRAM between NUM_REQ hash cores, for the multi-core bitcoin build.
- Each core drives the same mem_we/mem_addr/mem_write_data/mem_read_data interface as simplified_sha256, plus a req/gnt handshake.
- Arbitration is round-robin. A lock input gives burst ownership, capped at MAX_BURST grants.
- Read data returns one cycle after the grant, tagged per requester.

Parameters:
- NUM_REQ, 4, number of requesting cores (2..8).
- ADDR_W, 16, memory address width.
- DATA_W, 32, memory word width.
- MAX_BURST, 16, max consecutive grants to one locked owner while others wait (>=1).

Ports:
- clk  in  1  system clock; memory is also clocked on clk.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-core access request; held until granted.
- req_lock  in  NUM_REQ  per-core burst lock; sampled with req.
- req_we  in  NUM_REQ  per-core write enable (1=write, 0=read).
- req_addr  in  NUM_REQ*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  per-core write data, packed the same way.
- gnt  out  NUM_REQ  one-hot grant; access performed this cycle.
- rvalid  out  NUM_REQ  one-hot; rdata belongs to this core.
- rdata  out  DATA_W  shared read data.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_read_data  in  DATA_W  memory read data; valid the cycle after the address is sampled.

Behaviour:
- **Memory model:** the memory samples mem_we/mem_addr/mem_write_data at posedge clk. Read data appears on mem_read_data after that edge.
- **Grant timing:** gnt is combinational from req, the state, rr_ptr and lock_cnt. A grant in cycle T means the access is issued in cycle T. The core may change req/addr from T+1.
- **Grant encoding:** at most one gnt bit per cycle. gnt=0 whenever reset=1.
- **Idle memory outputs:** with no grant, mem_we=0, mem_addr=0, mem_write_data=0. No spurious writes.
- **Granted memory outputs:** with gnt[i]=1, the mem_* outputs are the mux of core i inputs.
- **Read return:** rvalid[i] is registered and equals 1 in T+1 iff gnt[i]=1 and req_we[i]=0 in T. rdata = mem_read_data, passed through.
- **Write return:** writes produce no rvalid.
- **States:** ARB and LOCKED.
  - ARB: grant the first asserted req searching from rr_ptr upward, with wrap-around modulo NUM_REQ. After the grant, rr_ptr <= winner+1 (wrapping). If the winner has req_lock=1, go to LOCKED with owner <= winner and lock_cnt <= 1.
  - LOCKED: if req[owner]=1 and req_lock[owner]=1, grant owner and lock_cnt++. Exception: if lock_cnt==MAX_BURST and any other req is asserted, grant nobody to the owner; arbitrate as in ARB starting from owner+1, excluding owner, and the chosen winner follows the ARB rules.
  - LOCKED exit: if req[owner]=0 or req_lock[owner]=0, return to ARB in the same cycle with rr_ptr = owner+1, and arbitrate normally this cycle (no dead cycle).
  - Cap reached, nobody else waiting: owner keeps the grant, and lock_cnt saturates at MAX_BURST.
- **rr_ptr update:** rr_ptr updates only on grants made in ARB. A lock continuation leaves rr_ptr unchanged.
- **Reset values** (synchronous, effective at the next posedge):
  - state=ARB, rr_ptr=0, owner=0, lock_cnt=0, rvalid=0.
  - After reset, core 0 has highest priority.
- **Reset mid-burst:** a reset during LOCKED abandons the lock. A pending rvalid is cleared, and any read in flight is dropped.
- **Simultaneous requests:** simultaneous req from all cores with no lock gives strict rotation, one grant per cycle, with 100% memory utilisation.
- **Lock on non-winners:** req_lock on a non-winning core has no effect until that core wins.

Test Plan:
- **Single read:** after reset, memory word 5 = 32'hDEADBEEF. Core 2 asserts req=1, we=0, addr=5 → gnt=4'b0100 the same cycle; next cycle rvalid=4'b0100 and rdata=32'hDEADBEEF.
- **Rotation:** all 4 cores hold req with no lock from reset → grant order 0,1,2,3,0,1… one per cycle; mem_we=0 on no-grant cycles.
- **Burst cap:** core 1 locks a 20-word read from addr 0 while core 3 requests from cycle 0 → core 1 gets 16 consecutive grants, then core 3 gets one grant, then core 1 regains the lock and finishes its remaining 4 words. rdata matches addresses 0..19 in order.
- **Lock release:** core 0 locks for 3 words, then drops req_lock with core 2 waiting → core 2 is granted in the cycle core 0 drops the lock, with no idle cycle.
- **Write then read-back:** core 1 writes 32'h01234567 to addr 1000, then core 0 reads addr 1000 → rvalid=4'b0001 with rdata=32'h01234567.
- **Reset mid-burst:** reset is asserted during LOCKED with a read in flight → next cycle gnt=0 and rvalid=0. After release, a request from core 0 wins over core 3 (rr_ptr=0).

Source files
------------

// File: rtl/sha256_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ hash cores,
// with capped burst locking and per-requester tagged read return.
module sha256_mem_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_lock,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic                        mem_clk,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_write_data,
   input  logic [DATA_W-1:0]           mem_read_data
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CAP = CW'(MAX_BURST);

   typedef enum logic {ARB, LOCKED} state_t;

   state_t              state, state_n;
   logic [IW-1:0]       rr_ptr, rr_ptr_n;
   logic [IW-1:0]       owner, owner_n;
   logic [CW-1:0]       lock_cnt, lock_cnt_n;
   logic [NUM_REQ-1:0]  sel;
   logic [NUM_REQ-1:0]  cand;
   logic [NUM_REQ-1:0]  others;
   logic [IW-1:0]       start;
   logic [IW-1:0]       win;
   logic                do_arb;
   logic                found;
   logic                hold;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
      return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
   endfunction

   assign mem_clk = clk;
   assign rdata   = mem_read_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ARB;
         rr_ptr   <= '0;
         owner    <= '0;
         lock_cnt <= '0;
         rvalid   <= '0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         owner    <= owner_n;
         lock_cnt <= lock_cnt_n;
         rvalid   <= sel & ~req_we;
      end
   end

   always_comb begin
      state_n    = state;
      rr_ptr_n   = rr_ptr;
      owner_n    = owner;
      lock_cnt_n = lock_cnt;
      sel        = '0;
      cand       = '0;
      start      = rr_ptr;
      do_arb     = 1'b0;
      found      = 1'b0;
      win        = '0;
      others     = req & ~(NUM_REQ'(1) << owner);
      hold       = req[owner] & req_lock[owner];
      unique case (state)
         ARB: begin
            do_arb = 1'b1;
            cand   = req;
         end
         LOCKED: begin
            if (hold && !((lock_cnt == CAP) && (|others))) begin
               sel[owner] = 1'b1;
               if (lock_cnt != CAP) lock_cnt_n = lock_cnt + 1'b1;
            end else begin
               // Cap handoff excludes the owner; a dropped lock arbitrates
               // from owner+1 in this same cycle so no slot is wasted.
               do_arb = 1'b1;
               start  = wrap_inc(owner);
               if (hold) begin
                  cand = others;
               end else begin
                  cand     = req;
                  state_n  = ARB;
                  rr_ptr_n = wrap_inc(owner);
               end
            end
         end
      endcase
      if (do_arb) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && cand[(k + 32'(start)) % NUM_REQ]) begin
               found = 1'b1;
               win   = IW'((k + 32'(start)) % NUM_REQ);
            end
         end
         if (found) begin
            sel[win] = 1'b1;
            rr_ptr_n = wrap_inc(win);
            if (req_lock[win]) begin
               state_n    = LOCKED;
               owner_n    = win;
               lock_cnt_n = CW'(1);
            end else begin
               state_n = ARB;
            end
         end
      end
   end

   always_comb begin
      gnt            = reset ? '0 : sel;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            mem_we         = req_we[i];
            mem_addr       = req_addr[i*ADDR_W +: ADDR_W];
            mem_write_data = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Directed and randomized bench for sha256_mem_arbiter against a
// transaction-level arbitration model and a shadow memory.
module tb_sha256_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req, req_lock, req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata, mem_write_data, mem_read_data;
   logic            mem_clk, mem_we;
   logic [AW-1:0]   mem_addr;

   always #5 clk = ~clk;

   sha256_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req(req), .req_lock(req_lock), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
      .rdata(rdata), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   function automatic logic [31:0] init_word(input logic [15:0] a);
      if (a == 16'd5) return 32'hDEADBEEF;
      return {a, a ^ 16'hA5C3};
   endfunction

   // SRAM environment: unwritten words read back their init pattern
   logic [31:0] tbm [1024];
   bit          tbw [1024];
   always @(posedge clk) begin
      if (mem_we) begin
         tbm[mem_addr[9:0]] <= mem_write_data;
         tbw[mem_addr[9:0]] <= 1'b1;
      end
      mem_read_data <= tbw[mem_addr[9:0]] ? tbm[mem_addr[9:0]] : init_word(mem_addr);
   end

   int total = 0;
   int bad   = 0;

   int          m_rr, m_owner, m_cnt;
   bit          m_locked;
   logic [3:0]  exp_rv;
   logic [31:0] exp_rd;
   logic [31:0] shm [1024];
   bit          shw [1024];

   int          rem [N];
   int          lkl [N];
   logic [15:0] ad  [N];
   logic [31:0] wd  [N];
   logic        wev [N];

   logic [3:0]  gq  [$];
   logic [3:0]  rvq [$];
   logic [31:0] rdq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic int search(input logic [3:0] r, input int start);
      for (int k = 0; k < N; k++)
         if (r[(start + k) % N]) return (start + k) % N;
      return -1;
   endfunction

   function automatic int model_grant();
      logic [3:0] oth;
      if (reset) return -1;
      if (!m_locked) return search(req, m_rr);
      if (req[m_owner] && req_lock[m_owner]) begin
         oth = req;
         oth[m_owner] = 1'b0;
         if (m_cnt == MB && oth != 4'b0) return search(oth, (m_owner + 1) % N);
         return m_owner;
      end
      return search(req, (m_owner + 1) % N);
   endfunction

   task automatic model_update(input int g);
      if (reset) begin
         m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0; exp_rv = '0;
         return;
      end
      exp_rv = '0;
      if (g >= 0) begin
         if (!wev[g]) begin
            exp_rv[g] = 1'b1;
            exp_rd = shw[ad[g][9:0]] ? shm[ad[g][9:0]] : init_word(ad[g]);
         end else begin
            shm[ad[g][9:0]] = wd[g];
            shw[ad[g][9:0]] = 1'b1;
         end
      end
      if (m_locked && req[m_owner] && req_lock[m_owner] && g == m_owner) begin
         m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
      end else begin
         if (m_locked) begin
            m_locked = 1'b0;
            m_rr = (m_owner + 1) % N;
         end
         if (g >= 0) begin
            m_rr = (g + 1) % N;
            if (req_lock[g]) begin
               m_locked = 1'b1; m_owner = g; m_cnt = 1;
            end
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req[i]      = rem[i] > 0;
         req_lock[i] = rem[i] > 0 && lkl[i] > 0;
         req_we[i]   = wev[i];
         req_addr[i*AW +: AW]  = ad[i];
         req_wdata[i*DW +: DW] = wd[i];
      end
   endtask

   task automatic clear_agents();
      for (int i = 0; i < N; i++) begin
         rem[i] = 0; lkl[i] = 0; ad[i] = '0; wd[i] = '0; wev[i] = 1'b0;
      end
   endtask

   task automatic clear_q();
      gq.delete(); rvq.delete(); rdq.delete();
   endtask

   task automatic cycle();
      int g;
      logic [3:0] eg;
      drive();
      #1;
      g  = model_grant();
      eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("mem_we", 32'(mem_we), (g >= 0) ? 32'(wev[g]) : 32'd0);
      chk("mem_addr", 32'(mem_addr), (g >= 0) ? 32'(ad[g]) : 32'd0);
      chk("mem_wdata", mem_write_data, (g >= 0) ? wd[g] : 32'd0);
      chk("rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv != 4'b0) chk("rdata", rdata, exp_rd);
      gq.push_back(gnt); rvq.push_back(rvalid); rdq.push_back(rdata);
      @(posedge clk);
      model_update(g);
      if (g >= 0) begin
         rem[g]--;
         if (lkl[g] > 0) lkl[g]--;
         ad[g] = ad[g] + 16'd1;
         wd[g] = $urandom;
      end
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_reset();
      clear_agents();
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      clear_q();
   endtask

   initial begin
      int k;
      logic [3:0] bexp [21];
      logic [3:0] lexp [7];

      clear_agents();
      reset = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_rr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0; exp_rv = '0; exp_rd = '0;
      chk("mem_clk", 32'(mem_clk), 32'(clk));

      // reset holds off grants even with every core requesting
      for (int i = 0; i < N; i++) rem[i] = 3;
      clear_q();
      cycle();
      chk("reset_gnt", 32'(gq[0]), 32'd0);
      chk("reset_rvalid", 32'(rvq[0]), 32'd0);
      clear_agents();
      reset = 1'b0;

      clear_q();
      rem[2] = 1; ad[2] = 16'd5;
      run(2);
      chk("single_gnt", 32'(gq[0]), 32'h4);
      chk("single_rvalid", 32'(rvq[1]), 32'h4);
      chk("single_rdata", rdq[1], 32'hDEADBEEF);

      do_reset();
      for (int i = 0; i < N; i++) begin rem[i] = 100; ad[i] = 16'(200 + 16 * i); end
      run(8);
      for (int c = 0; c < 8; c++) chk($sformatf("rot%0d", c), 32'(gq[c]), 32'(4'b0001 << (c % 4)));
      clear_agents();
      run(2);

      do_reset();
      rem[1] = 20; lkl[1] = 20; ad[1] = 16'd0;
      rem[3] = 1;  ad[3] = 16'd100;
      run(24);
      for (int c = 0; c < 21; c++) bexp[c] = 4'b0010;
      bexp[16] = 4'b1000;
      for (int c = 0; c < 21; c++) chk($sformatf("burst_gnt%0d", c), 32'(gq[c]), 32'(bexp[c]));
      chk("burst_idle", 32'(gq[21]), 32'd0);
      k = 0;
      for (int j = 0; j < rvq.size(); j++) begin
         if (rvq[j] == 4'b0010) begin
            chk($sformatf("burst_rd%0d", k), rdq[j], init_word(16'(k)));
            k++;
         end
      end
      chk("burst_rd_count", 32'(k), 32'd20);

      do_reset();
      rem[0] = 5; lkl[0] = 3; ad[0] = 16'd300;
      rem[2] = 1; ad[2] = 16'd400;
      run(7);
      lexp = '{4'h1, 4'h1, 4'h1, 4'h4, 4'h1, 4'h1, 4'h0};
      for (int c = 0; c < 7; c++) chk($sformatf("release_gnt%0d", c), 32'(gq[c]), 32'(lexp[c]));

      do_reset();
      rem[1] = 1; wev[1] = 1'b1; ad[1] = 16'd1000; wd[1] = 32'h01234567;
      run(1);
      rem[0] = 1; ad[0] = 16'd1000;
      run(2);
      chk("wr_gnt", 32'(gq[0]), 32'h2);
      chk("rd_gnt", 32'(gq[1]), 32'h1);
      chk("rb_rvalid", 32'(rvq[2]), 32'h1);
      chk("rb_rdata", rdq[2], 32'h01234567);

      do_reset();
      rem[1] = 10; lkl[1] = 10; ad[1] = 16'd500;
      run(4);
      clear_q();
      reset = 1'b1;
      run(2);
      chk("midrst_gnt0", 32'(gq[0]), 32'd0);
      chk("midrst_gnt1", 32'(gq[1]), 32'd0);
      chk("midrst_inflight", 32'(rvq[0]), 32'h2);
      chk("midrst_rvalid", 32'(rvq[1]), 32'd0);
      clear_agents();
      reset = 1'b0;
      rem[0] = 1; ad[0] = 16'd600;
      rem[3] = 1; ad[3] = 16'd700;
      clear_q();
      run(3);
      chk("post_rst_c0", 32'(gq[0]), 32'h1);
      chk("post_rst_c3", 32'(gq[1]), 32'h8);

      // randomized traffic with occasional long locked bursts and resets
      clear_agents();
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
               rem[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 22))
                                                    : int'($urandom_range(1, 6));
               lkl[i] = ($urandom_range(0, 1) == 1) ? rem[i] : int'($urandom_range(0, rem[i]));
               wev[i] = ($urandom_range(0, 2) == 0);
               ad[i]  = 16'($urandom_range(0, 63));
               wd[i]  = $urandom;
            end
         end
         reset = ($urandom_range(0, 149) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
